// File: rtl/counter_cmd_sched.sv
// Round-robin command scheduler driving a shared 2-bit up/down counter datapath.
// Requesters hand over INC/DEC bursts, LOAD or CLR commands; the block sequences
// the counter control pins and returns the final count plus the wrap tally.
module counter_cmd_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [2*N_REQ-1:0]         req_op,
  input  logic [LEN_W*N_REQ-1:0]     req_len,
  input  logic [2*N_REQ-1:0]         req_data,
  output logic                       cnt_en,
  output logic                       cnt_up,
  output logic                       cnt_load,
  output logic [1:0]                 cnt_load_val,
  output logic                       cnt_clr,
  input  logic [1:0]                 cnt_q,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [1:0]                 rsp_count,
  output logic [LEN_W-1:0]           rsp_wraps
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned SUM_W = ID_W + 1;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STROBE, S_RSP} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [LEN_W-1:0]  remain;
  logic              rsp_first;
  logic [1:0]        rsp_hold;

  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic              wrap_hit;

  logic [1:0]        op_arr   [N_REQ];
  logic [1:0]        data_arr [N_REQ];
  logic [LEN_W-1:0]  len_arr  [N_REQ];

  // Split the flat per-requester buses into indexable fields
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr[g]   = req_op[2*g +: 2];
    assign data_arr[g] = req_data[2*g +: 2];
    assign len_arr[g]  = req_len[LEN_W*g +: LEN_W];
  end

  // Pick the first valid requester at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [ID_W-1:0]  idx;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
      idx = sum[ID_W-1:0];
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Accept strobe exists only while idle, for the winner only
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  // Wrap occurs when the step crosses the 3<->0 boundary
  assign wrap_hit = (cnt_up && cnt_q == 2'd3) || (!cnt_up && cnt_q == 2'd0);

  // The counter settles on the edge entering RSP, so the first RSP cycle passes cnt_q through
  assign rsp_count = !rsp_valid ? 2'd0 : (rsp_first ? cnt_q : rsp_hold);

  // Command sequencer with registered counter controls and response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      remain       <= '0;
      rsp_first    <= 1'b0;
      rsp_hold     <= 2'd0;
      cnt_en       <= 1'b0;
      cnt_up       <= 1'b0;
      cnt_load     <= 1'b0;
      cnt_load_val <= 2'd0;
      cnt_clr      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_wraps    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            rsp_id    <= grant_idx;
            rsp_wraps <= '0;
            rr_ptr    <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            if (op_arr[grant_idx] == OP_INC || op_arr[grant_idx] == OP_DEC) begin
              if (len_arr[grant_idx] != '0) begin
                state  <= S_RUN;
                remain <= len_arr[grant_idx];
                cnt_en <= 1'b1;
                cnt_up <= (op_arr[grant_idx] == OP_INC);
              end else begin
                state     <= S_RSP;
                rsp_valid <= 1'b1;
                rsp_first <= 1'b1;
              end
            end else if (op_arr[grant_idx] == OP_LOAD) begin
              state        <= S_STROBE;
              cnt_load     <= 1'b1;
              cnt_load_val <= data_arr[grant_idx];
            end else begin
              state   <= S_STROBE;
              cnt_clr <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (wrap_hit && rsp_wraps != '1) rsp_wraps <= rsp_wraps + LEN_W'(1);
          remain <= remain - LEN_W'(1);
          if (remain == LEN_W'(1)) begin
            state     <= S_RSP;
            cnt_en    <= 1'b0;
            cnt_up    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_first <= 1'b1;
          end
        end
        S_STROBE: begin
          state        <= S_RSP;
          cnt_load     <= 1'b0;
          cnt_load_val <= 2'd0;
          cnt_clr      <= 1'b0;
          rsp_valid    <= 1'b1;
          rsp_first    <= 1'b1;
        end
        S_RSP: begin
          rsp_first <= 1'b0;
          if (rsp_first) rsp_hold <= cnt_q;
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Directed bench for counter_cmd_sched with a behavioural 2-bit counter datapath.
module tb_counter_cmd_sched;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned ID_W  = 2;

  localparam logic [1:0] INC  = 2'b00;
  localparam logic [1:0] DEC  = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op;
  logic [LEN_W*N_REQ-1:0] req_len;
  logic [2*N_REQ-1:0]     req_data;
  logic                   cnt_en, cnt_up, cnt_load, cnt_clr;
  logic [1:0]             cnt_load_val;
  logic [1:0]             cnt_q;
  logic                   rsp_valid, rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [1:0]             rsp_count;
  logic [LEN_W-1:0]       rsp_wraps;

  logic                   preset_en;
  logic [1:0]             preset_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_cmd_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_len(req_len), .req_data(req_data),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .cnt_clr(cnt_clr), .cnt_q(cnt_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_count(rsp_count), .rsp_wraps(rsp_wraps)
  );

  // Counter datapath model; preset lets the bench seed a starting count
  always @(posedge clk) begin
    if (preset_en)     cnt_q <= preset_val;
    else if (cnt_clr)  cnt_q <= 2'd0;
    else if (cnt_load) cnt_q <= cnt_load_val;
    else if (cnt_en)   cnt_q <= cnt_up ? cnt_q + 2'd1 : cnt_q - 2'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    #4;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] len, input logic [1:0] data);
    req_op[2*i +: 2]   = op;
    req_len[4*i +: 4]  = len;
    req_data[2*i +: 2] = data;
  endtask

  task automatic preset(input logic [1:0] v);
    tick();
    preset_en  = 1'b1;
    preset_val = v;
    tick();
    preset_en  = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cyc, output int lat);
    lat = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      if (c == 1) req_valid = '0;
      samp();
      if (rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      failures++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", max_cyc);
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_len = '0; req_data = '0;
    rsp_ready = 1'b1; preset_en = 1'b1; preset_val = 2'd0;
    repeat (2) tick();
    samp();
    checks++;
    if ({cnt_en, cnt_up, cnt_load, cnt_clr, cnt_load_val, rsp_valid, rsp_id, rsp_count, rsp_wraps, req_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: en=%b up=%b ld=%b clr=%b rv=%b ready=%b expected all 0",
               cnt_en, cnt_up, cnt_load, cnt_clr, rsp_valid, req_ready);
    end
    tick();
    rst_n = 1'b1; preset_en = 1'b0;
    set_req(1, INC, 4'd8, 2'd0);
    req_valid = 4'b0010;
    samp();
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL t1_grant_req1: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = '0;
    samp();
    checks++;
    if (cnt_en !== 1'b1 || cnt_up !== 1'b1) begin
      failures++; $display("FAIL t1_run: en=%b up=%b expected 1 1", cnt_en, cnt_up);
    end
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt_en, cnt_up, cnt_load, cnt_clr, cnt_load_val, rsp_valid, rsp_id, rsp_count, rsp_wraps, req_ready} !== '0) begin
      failures++;
      $display("FAIL t1_async_abort: en=%b up=%b ld=%b clr=%b rv=%b wraps=%0d expected all 0",
               cnt_en, cnt_up, cnt_load, cnt_clr, rsp_valid, rsp_wraps);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, CLR, 4'd0, 2'd0);
    req_valid = 4'b1111;
    samp();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL t1_first_after_reset: got %b expected 0001", req_ready);
    end
    wait_rsp(5, lat);
    checks++;
    if (lat != 2 || rsp_id !== 2'd0 || rsp_count !== 2'd0) begin
      failures++; $display("FAIL t1_clr_rsp: lat=%0d id=%0d count=%0d expected 2 0 0", lat, rsp_id, rsp_count);
    end
  endtask

  task automatic test_inc_burst();
    preset(2'd1);
    set_req(2, INC, 4'd5, 2'd0);
    req_valid = 4'b0100;
    samp();
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL t2_grant: got %b expected 0100", req_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) req_valid = '0;
      samp();
      checks++;
      if (cnt_en !== 1'b1 || cnt_up !== 1'b1 || rsp_valid !== 1'b0) begin
        failures++; $display("FAIL t2_step%0d: en=%b up=%b rv=%b expected 1 1 0", k, cnt_en, cnt_up, rsp_valid);
      end
    end
    tick();
    samp();
    checks++;
    if (rsp_valid !== 1'b1 || cnt_en !== 1'b0) begin
      failures++; $display("FAIL t2_latency: rv=%b en=%b expected 1 0 at G+6", rsp_valid, cnt_en);
    end
    checks++;
    if (rsp_count !== 2'd2) begin
      failures++; $display("FAIL t2_count: got %0d expected 2", rsp_count);
    end
    checks++;
    if (rsp_wraps !== 4'd1) begin
      failures++; $display("FAIL t2_wraps: got %0d expected 1", rsp_wraps);
    end
    checks++;
    if (rsp_id !== 2'd2) begin
      failures++; $display("FAIL t2_id: got %0d expected 2", rsp_id);
    end
  endtask

  task automatic test_dec_wrap();
    int lat;
    preset(2'd0);
    set_req(1, DEC, 4'd9, 2'd0);
    req_valid = 4'b0010;
    samp();
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL t3_grant: got %b expected 0010", req_ready);
    end
    wait_rsp(20, lat);
    checks++;
    if (lat != 10) begin
      failures++; $display("FAIL t3_latency: got %0d expected 10", lat);
    end
    checks++;
    if (rsp_count !== 2'd3 || rsp_wraps !== 4'd3 || rsp_id !== 2'd1) begin
      failures++; $display("FAIL t3_rsp: count=%0d wraps=%0d id=%0d expected 3 3 1", rsp_count, rsp_wraps, rsp_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n = 0;
    int lat;
    logic [3:0] exp_ready;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, CLR, 4'd0, 2'd0);
    req_valid = 4'b1111;
    samp();
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (c > 0) begin
        tick();
        samp();
      end
      checks++;
      if ($countones(req_ready) > 1 || (rsp_valid === 1'b1 && req_ready !== 4'b0000)) begin
        failures++; $display("FAIL t4_exclusive: ready=%b rv=%b", req_ready, rsp_valid);
      end
      if (req_ready !== 4'b0000) begin
        exp_ready = 4'b0001 << exp_order[n];
        checks++;
        if (req_ready !== exp_ready) begin
          failures++; $display("FAIL t4_order%0d: got %b expected %b", n, req_ready, exp_ready);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL t4_grant_count: got %0d expected 5", n);
    end
    wait_rsp(5, lat);
    checks++;
    if (lat != 2 || rsp_id !== 2'd0) begin
      failures++; $display("FAIL t4_last_rsp: lat=%0d id=%0d expected 2 0", lat, rsp_id);
    end
  endtask

  task automatic test_load_clr();
    preset(2'd0);
    set_req(3, LOAD, 4'd0, 2'd2);
    req_valid = 4'b1000;
    samp();
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL t5_load_grant: got %b expected 1000", req_ready);
    end
    tick();
    req_valid = '0;
    set_req(3, LOAD, 4'd0, 2'd1);
    samp();
    checks++;
    if (cnt_load !== 1'b1 || cnt_load_val !== 2'd2 || cnt_en !== 1'b0 || cnt_clr !== 1'b0) begin
      failures++; $display("FAIL t5_load_strobe: ld=%b val=%0d en=%b clr=%b expected 1 2 0 0",
                           cnt_load, cnt_load_val, cnt_en, cnt_clr);
    end
    tick();
    samp();
    checks++;
    if (rsp_valid !== 1'b1 || cnt_load !== 1'b0) begin
      failures++; $display("FAIL t5_load_rsp: rv=%b ld=%b expected 1 0", rsp_valid, cnt_load);
    end
    checks++;
    if (rsp_count !== 2'd2 || rsp_wraps !== 4'd0 || rsp_id !== 2'd3) begin
      failures++; $display("FAIL t5_load_fields: count=%0d wraps=%0d id=%0d expected 2 0 3", rsp_count, rsp_wraps, rsp_id);
    end
    tick();
    set_req(3, CLR, 4'd0, 2'd0);
    req_valid = 4'b1000;
    samp();
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL t5_clr_grant: got %b expected 1000", req_ready);
    end
    tick();
    req_valid = '0;
    samp();
    checks++;
    if (cnt_clr !== 1'b1 || cnt_load !== 1'b0 || cnt_en !== 1'b0) begin
      failures++; $display("FAIL t5_clr_strobe: clr=%b ld=%b en=%b expected 1 0 0", cnt_clr, cnt_load, cnt_en);
    end
    tick();
    samp();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_count !== 2'd0 || cnt_clr !== 1'b0) begin
      failures++; $display("FAIL t5_clr_rsp: rv=%b count=%0d clr=%b expected 1 0 0", rsp_valid, rsp_count, cnt_clr);
    end
  endtask

  task automatic test_backpressure_len0();
    int lat;
    preset(2'd3);
    rsp_ready = 1'b0;
    set_req(0, INC, 4'd2, 2'd0);
    req_valid = 4'b0001;
    samp();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL t6_grant: got %b expected 0001", req_ready);
    end
    wait_rsp(10, lat);
    checks++;
    if (lat != 3 || rsp_count !== 2'd1 || rsp_wraps !== 4'd1) begin
      failures++; $display("FAIL t6_rsp: lat=%0d count=%0d wraps=%0d expected 3 1 1", lat, rsp_count, rsp_wraps);
    end
    set_req(1, INC, 4'd0, 2'd0);
    req_valid = 4'b0010;
    #1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      samp();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_count !== 2'd1 || rsp_wraps !== 4'd1 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
        failures++; $display("FAIL t6_hold%0d: rv=%b count=%0d wraps=%0d id=%0d ready=%b expected 1 1 1 0 0000",
                             k, rsp_valid, rsp_count, rsp_wraps, rsp_id, req_ready);
      end
    end
    tick();
    rsp_ready = 1'b1;
    samp();
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL t6_accept: rv=%b ready=%b expected 1 0000", rsp_valid, req_ready);
    end
    tick();
    samp();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      failures++; $display("FAIL t6_len0_grant: rv=%b ready=%b expected 0 0010", rsp_valid, req_ready);
    end
    tick();
    req_valid = '0;
    samp();
    checks++;
    if (rsp_valid !== 1'b1 || cnt_en !== 1'b0 || rsp_id !== 2'd1 || rsp_count !== 2'd1 || rsp_wraps !== 4'd0) begin
      failures++; $display("FAIL t6_len0_rsp: rv=%b en=%b id=%0d count=%0d wraps=%0d expected 1 0 1 1 0",
                           rsp_valid, cnt_en, rsp_id, rsp_count, rsp_wraps);
    end
  endtask

  initial begin
    test_reset();
    test_inc_burst();
    test_dec_wrap();
    test_round_robin();
    test_load_clr();
    test_backpressure_len0();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
